// File: rtl/onehot_driver_3x8_pkg.sv
// Shared constants and state encoding for the 3-to-8 one-hot driver.
package onehot_driver_3x8_pkg;

  localparam int NUM_CH = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_dec_3x8.sv
// Pure combinational 3-bit binary to 8-line one-hot decode.
module onehot_dec_3x8
  import onehot_driver_3x8_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [NUM_CH-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/onehot_driver_3x8.sv
// Registered 3-to-8 one-hot driver with programmable hold time and an
// optional sweep of all channels; feeds the per-band output stages.
module onehot_driver_3x8
  import onehot_driver_3x8_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                code_valid,
  input  logic [CODE_W-1:0]   code_in,
  output logic                code_ready,
  input  logic                scan_en,
  output logic [NUM_CH-1:0]   onehot_out,
  output logic                active,
  output logic                done
);

  localparam logic [CNT_W-1:0]  RELOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(NUM_CH - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [CODE_W-1:0]   idx, idx_nx;
  logic [NUM_CH-1:0]   oh_q, oh_nx;
  logic                done_q, done_nx;
  logic [CODE_W-1:0]   dec_code;
  logic [NUM_CH-1:0]   dec_oh;

  // Handshake: a code transfers on any cycle where code_valid && code_ready;
  // code_ready is only high in IDLE while enabled, so a source must hold
  // code_valid and code_in stable until that cycle.
  assign code_ready = enable && (state == ST_IDLE);

  // One decoder serves both the accepted code (IDLE) and the next scan line.
  assign dec_code = (state == ST_IDLE) ? code_in : idx + CODE_W'(1);

  onehot_dec_3x8 u_dec (
    .code   (dec_code),
    .onehot (dec_oh)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    oh_nx    = oh_q;
    done_nx  = 1'b0;
    if (enable) begin
      case (state)
        ST_IDLE: begin
          if (code_valid) begin
            oh_nx    = dec_oh;
            cnt_nx   = RELOAD;
            state_nx = ST_HOLD;
          end else if (scan_en) begin
            oh_nx    = NUM_CH'(1);
            idx_nx   = '0;
            cnt_nx   = RELOAD;
            state_nx = ST_SCAN;
          end
        end
        ST_HOLD: begin
          if (cnt != '0) begin
            cnt_nx = cnt - CNT_W'(1);
          end else begin
            oh_nx    = '0;
            done_nx  = 1'b1;
            state_nx = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (cnt != '0) begin
            cnt_nx = cnt - CNT_W'(1);
          end else begin
            // The wrap step reports done even if the sweep stops there.
            done_nx = (idx == LAST_IDX);
            if (scan_en) begin
              idx_nx = idx + CODE_W'(1);
              oh_nx  = dec_oh;
              cnt_nx = RELOAD;
            end else begin
              oh_nx    = '0;
              state_nx = ST_IDLE;
            end
          end
        end
        default: begin
          oh_nx    = '0;
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      idx    <= '0;
      oh_q   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      oh_q   <= oh_nx;
      done_q <= done_nx;
    end
  end

  assign onehot_out = oh_q;
  assign active     = |oh_q;
  assign done       = done_q && enable;

endmodule
